// File: rtl/branch_pc_unit.sv
// Program-counter and branch-resolution unit: picks the next PC from the decoded
// control-flow class and the comparator results, traps misaligned targets, and counts branches.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [2:0]  funct3,
  input  logic        BrLT,
  input  logic        BrEQ,
  input  logic [31:0] target,
  output logic        BrUn,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        taken,
  output logic        trap,
  output logic [31:0] bad_addr,
  output logic [15:0] branch_cnt,
  output logic [15:0] taken_cnt
);

  // state  | meaning
  // S_RUN  | normal retirement; instructions may advance the PC
  // S_TRAP | single cycle after a misaligned redirect; incoming instruction is flushed
  typedef enum logic {S_RUN = 1'b0, S_TRAP = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] bad_addr_q, bad_addr_d;
  logic        trap_q, trap_d;
  logic [15:0] branch_cnt_q, branch_cnt_d;
  logic [15:0] taken_cnt_q, taken_cnt_d;

  logic        cond;
  logic        win_branch;
  logic        advance;
  logic        misaligned;
  logic [31:0] eff_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (advance && misaligned) state_d = S_TRAP;
      S_TRAP:  state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  cond = BrEQ;
      3'b001:  cond = !BrEQ;
      3'b100:  cond = BrLT;
      3'b101:  cond = !BrLT;
      3'b110:  cond = BrLT;
      3'b111:  cond = !BrLT;
      default: cond = 1'b0;
    endcase
    BrUn       = funct3[2] & funct3[1];
    win_branch = is_branch & !is_jal & !is_jalr;
    eff_target = is_jalr ? {target[31:1], 1'b0} : target;
    taken      = (state_q == S_RUN) & (is_jalr | is_jal | (is_branch & cond));
    misaligned = taken & (eff_target[1:0] != 2'b00);
    advance    = instr_valid & !stall & (state_q == S_RUN);
  end

  assign pc_plus4 = pc_q + 32'd4;

  // Counters and PC only move on an advancing cycle; the TRAP cycle never advances.
  always_comb begin
    pc_d         = pc_q;
    bad_addr_d   = bad_addr_q;
    trap_d       = 1'b0;
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (advance) begin
      if (misaligned) begin
        pc_d       = TRAP_VEC;
        bad_addr_d = eff_target;
        trap_d     = 1'b1;
      end else if (taken) begin
        pc_d = eff_target;
      end else begin
        pc_d = pc_plus4;
      end
      if (win_branch) begin
        if (branch_cnt_q != 16'hFFFF) branch_cnt_d = branch_cnt_q + 16'd1;
        if (taken && taken_cnt_q != 16'hFFFF) taken_cnt_d = taken_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      bad_addr_q   <= 32'h0000_0000;
      trap_q       <= 1'b0;
      branch_cnt_q <= 16'h0000;
      taken_cnt_q  <= 16'h0000;
    end else begin
      pc_q         <= pc_d;
      bad_addr_q   <= bad_addr_d;
      trap_q       <= trap_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign pc         = pc_q;
  assign bad_addr   = bad_addr_q;
  assign trap       = trap_q;
  assign branch_cnt = branch_cnt_q;
  assign taken_cnt  = taken_cnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid, stall, is_branch, is_jal, is_jalr;
  logic [2:0]  funct3;
  logic        BrLT, BrEQ;
  logic [31:0] target;
  logic        BrUn;
  logic [31:0] pc, pc_plus4, bad_addr;
  logic        taken, trap;
  logic [15:0] branch_cnt, taken_cnt;

  branch_pc_unit dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .stall(stall),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3),
    .BrLT(BrLT), .BrEQ(BrEQ), .target(target), .BrUn(BrUn), .pc(pc),
    .pc_plus4(pc_plus4), .taken(taken), .trap(trap), .bad_addr(bad_addr),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int          due;
    bit          seq;
    string       nm;
    logic [31:0] pc;
    logic [15:0] b;
    logic [15:0] t;
    logic        trap;
    logic [31:0] bad;
    logic        tk;
    logic        bu;
  } exp_t;

  exp_t q[$];

  function automatic void cmp(string nm, string fld, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, exp);
    end
  endfunction

  exp_t e;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      if (e.due < cyc) cmp(e.nm, "stale_expectation", 32'(e.due), 32'(cyc));
      if (e.seq) begin
        cmp(e.nm, "pc", pc, e.pc);
        cmp(e.nm, "pc_plus4", pc_plus4, e.pc + 32'd4);
        cmp(e.nm, "branch_cnt", {16'h0, branch_cnt}, {16'h0, e.b});
        cmp(e.nm, "taken_cnt", {16'h0, taken_cnt}, {16'h0, e.t});
        cmp(e.nm, "trap", {31'h0, trap}, {31'h0, e.trap});
        cmp(e.nm, "bad_addr", bad_addr, e.bad);
      end else begin
        cmp(e.nm, "taken", {31'h0, taken}, {31'h0, e.tk});
        cmp(e.nm, "BrUn", {31'h0, BrUn}, {31'h0, e.bu});
      end
    end
  end

  task automatic set_in(bit v, bit st, bit br, bit jl, bit jr, logic [2:0] f3,
                        bit lt, bit eq, logic [31:0] tg);
    instr_valid = v; stall = st; is_branch = br; is_jal = jl; is_jalr = jr;
    funct3 = f3; BrLT = lt; BrEQ = eq; target = tg;
  endtask

  task automatic exp_seq(string nm, int dly, logic [31:0] p, logic [15:0] b,
                         logic [15:0] t, logic tr, logic [31:0] bd);
    exp_t x;
    x.due = cyc + dly; x.seq = 1'b1; x.nm = nm; x.pc = p; x.b = b; x.t = t;
    x.trap = tr; x.bad = bd; x.tk = 1'b0; x.bu = 1'b0;
    q.push_back(x);
  endtask

  task automatic exp_comb(string nm, logic tk, logic bu);
    exp_t x;
    x.due = cyc; x.seq = 1'b0; x.nm = nm; x.pc = '0; x.b = '0; x.t = '0;
    x.trap = 1'b0; x.bad = '0; x.tk = tk; x.bu = bu;
    q.push_back(x);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Comb expectation for the current cycle, state expectation after the next edge.
  task automatic step(string nm, logic tk, logic bu, logic [31:0] p, logic [15:0] b,
                      logic [15:0] t, logic tr, logic [31:0] bd);
    exp_comb(nm, tk, bu);
    exp_seq(nm, 1, p, b, t, tr, bd);
    tick();
  endtask

  logic [2:0] f3_tab [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
  logic       bu_tab [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0);
    tick();
    exp_seq("reset", 0, 32'h0, 16'd0, 16'd0, 1'b0, 32'h0);
    tick();

    rst_n = 1'b1;
    set_in(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0);
    exp_seq("release", 0, 32'h0, 16'd0, 16'd0, 1'b0, 32'h0);
    step("seq1", 0, 0, 32'h4, 0, 0, 0, 32'h0);
    step("seq2", 0, 0, 32'h8, 0, 0, 0, 32'h0);
    step("seq3", 0, 0, 32'hC, 0, 0, 0, 32'h0);

    set_in(1, 0, 0, 1, 0, 3'b000, 0, 0, 32'h40);
    step("jal_40", 1, 0, 32'h40, 0, 0, 0, 32'h0);
    set_in(1, 0, 1, 0, 0, 3'b101, 0, 0, 32'h80);
    step("bge_taken", 1, 0, 32'h80, 1, 1, 0, 32'h0);
    set_in(1, 0, 0, 1, 0, 3'b000, 0, 0, 32'h40);
    step("jal_40b", 1, 0, 32'h40, 1, 1, 0, 32'h0);
    set_in(1, 0, 1, 0, 0, 3'b101, 1, 0, 32'h80);
    step("bge_not", 0, 0, 32'h44, 2, 1, 0, 32'h0);

    for (int i = 0; i < 6; i++) begin
      set_in(0, 0, 0, 0, 0, f3_tab[i], 1, 1, 32'h80);
      step($sformatf("brun_f3_%0d", i), 0, bu_tab[i], 32'h44, 2, 1, 0, 32'h0);
    end

    set_in(1, 0, 1, 0, 0, 3'b010, 1, 1, 32'h80);
    step("f3_010", 0, 0, 32'h48, 3, 1, 0, 32'h0);
    set_in(1, 0, 1, 0, 0, 3'b011, 1, 1, 32'h80);
    step("f3_011", 0, 0, 32'h4C, 4, 1, 0, 32'h0);
    set_in(1, 0, 1, 0, 0, 3'b000, 0, 1, 32'h60);
    step("beq_taken", 1, 0, 32'h60, 5, 2, 0, 32'h0);
    set_in(1, 0, 1, 0, 0, 3'b001, 0, 1, 32'h80);
    step("bne_not", 0, 0, 32'h64, 6, 2, 0, 32'h0);
    set_in(1, 0, 1, 0, 0, 3'b100, 1, 0, 32'h70);
    step("blt_taken", 1, 0, 32'h70, 7, 3, 0, 32'h0);
    set_in(1, 0, 1, 0, 0, 3'b110, 0, 0, 32'h80);
    step("bltu_not", 0, 1, 32'h74, 8, 3, 0, 32'h0);
    set_in(1, 0, 1, 0, 0, 3'b111, 0, 0, 32'h90);
    step("bgeu_taken", 1, 1, 32'h90, 9, 4, 0, 32'h0);
    set_in(1, 0, 1, 1, 1, 3'b000, 0, 0, 32'hA1);
    step("prio_jalr", 1, 0, 32'hA0, 9, 4, 0, 32'h0);
    set_in(1, 0, 1, 1, 0, 3'b010, 0, 0, 32'hB0);
    step("prio_jal", 1, 0, 32'hB0, 9, 4, 0, 32'h0);

    set_in(1, 0, 0, 0, 1, 3'b000, 0, 0, 32'h103);
    step("jalr_misal", 1, 0, 32'h100, 9, 4, 1, 32'h102);
    set_in(1, 0, 0, 1, 0, 3'b000, 0, 0, 32'h200);
    step("trap_flush", 0, 0, 32'h100, 9, 4, 0, 32'h102);
    set_in(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0);
    step("post_trap", 0, 0, 32'h104, 9, 4, 0, 32'h102);
    set_in(1, 0, 1, 0, 0, 3'b000, 0, 1, 32'h1F2);
    step("br_misal", 1, 0, 32'h100, 10, 5, 1, 32'h1F2);
    set_in(0, 1, 1, 0, 0, 3'b000, 0, 1, 32'h1F2);
    step("trap_exit_stalled", 0, 0, 32'h100, 10, 5, 0, 32'h1F2);

    set_in(1, 1, 1, 0, 0, 3'b000, 0, 1, 32'h300);
    for (int i = 0; i < 4; i++)
      step($sformatf("stall_%0d", i), 1, 0, 32'h100, 10, 5, 0, 32'h1F2);
    stall = 1'b0;
    step("stall_release", 1, 0, 32'h300, 11, 6, 0, 32'h1F2);

    set_in(1, 0, 0, 1, 0, 3'b000, 0, 0, 32'hFFFF_FFFC);
    step("jal_top", 1, 0, 32'hFFFF_FFFC, 11, 6, 0, 32'h1F2);
    set_in(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0);
    step("pc_wrap", 0, 0, 32'h0, 11, 6, 0, 32'h1F2);

    set_in(1, 0, 1, 0, 0, 3'b000, 0, 1, 32'h200);
    repeat (65528) @(posedge clk);
    #1;
    exp_seq("cnt_near_sat", 0, 32'h200, 16'hFFFF, 16'hFFFE, 0, 32'h1F2);
    step("cnt_reach_sat", 1, 0, 32'h200, 16'hFFFF, 16'hFFFF, 0, 32'h1F2);
    step("cnt_hold_sat", 1, 0, 32'h200, 16'hFFFF, 16'hFFFF, 0, 32'h1F2);

    set_in(1, 0, 0, 0, 1, 3'b000, 0, 0, 32'h103);
    step("trap_before_rst", 1, 0, 32'h100, 16'hFFFF, 16'hFFFF, 1, 32'h102);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    cmp("async_rst", "pc", pc, 32'h0);
    cmp("async_rst", "trap", {31'h0, trap}, 32'h0);
    cmp("async_rst", "bad_addr", bad_addr, 32'h0);
    cmp("async_rst", "branch_cnt", {16'h0, branch_cnt}, 32'h0);
    cmp("async_rst", "taken_cnt", {16'h0, taken_cnt}, 32'h0);
    set_in(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0);
    #1;
    rst_n = 1'b1;
    exp_seq("after_rst", 1, 32'h4, 0, 0, 0, 32'h0);
    tick();

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
